// File: rtl/fme_sad_accum.sv
// Nine-way SAD accumulator for fractional motion estimation: one current pixel
// against the integer centre and eight half-pel candidates per cycle, NPIX pixels per block.
module fme_sad_accum #(
    parameter int NPIX = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       cur,
    input  logic [8:0][7:0]  cand,
    output logic [8:0][15:0] distort,
    output logic             done,
    output logic             busy
);

    localparam int CW = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NPIX - 1);

    logic [CW-1:0]     pcnt_reg;
    logic              v1_reg;
    logic              last1_reg;
    logic              done_reg;
    logic [8:0][7:0]   diff_reg;
    logic [8:0][15:0]  acc_reg;
    logic [8:0][15:0]  distort_reg;
    logic [8:0][15:0]  sum_next;

    // Stage 1 control: pixel counter and block-end tag travelling with the diffs
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_reg  <= '0;
            v1_reg    <= 1'b0;
            last1_reg <= 1'b0;
        end else if (in_valid) begin
            v1_reg    <= 1'b1;
            last1_reg <= (pcnt_reg == LAST_IDX);
            pcnt_reg  <= (pcnt_reg == LAST_IDX) ? '0 : pcnt_reg + 1'b1;
        end else begin
            v1_reg    <= 1'b0;
        end
    end

    // Stage 2 control: the strobe rides with the distort write
    always_ff @(posedge clk) begin
        if (rst) begin
            done_reg <= 1'b0;
        end else begin
            done_reg <= v1_reg & last1_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_cand
            logic [16:0] sum_full;

            always_ff @(posedge clk) begin
                if (rst) begin
                    diff_reg[gi] <= '0;
                end else if (in_valid) begin
                    diff_reg[gi] <= (cur >= cand[gi]) ? (cur - cand[gi]) : (cand[gi] - cur);
                end
            end

            // A saturated accumulator plus any diff saturates again, so it stays pinned
            assign sum_full     = {1'b0, acc_reg[gi]} + {9'b0, diff_reg[gi]};
            assign sum_next[gi] = sum_full[16] ? 16'hFFFF : sum_full[15:0];

            always_ff @(posedge clk) begin
                if (rst) begin
                    acc_reg[gi]     <= '0;
                    distort_reg[gi] <= '0;
                end else if (v1_reg) begin
                    if (last1_reg) begin
                        distort_reg[gi] <= sum_next[gi];
                        acc_reg[gi]     <= '0;
                    end else begin
                        acc_reg[gi]     <= sum_next[gi];
                    end
                end
            end
        end
    endgenerate

    assign distort = distort_reg;
    assign done    = done_reg;
    assign busy    = (pcnt_reg != '0) | v1_reg;

endmodule

// File: tb/tb_fme_sad_accum.sv
// Scoreboard bench for fme_sad_accum: a 64-pixel instance for the main cases and
// a 512-pixel instance for saturation.
module tb_fme_sad_accum;

    typedef struct {
        logic [8:0][15:0] v;
        int               cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_valid_s;
    logic [7:0]       cur;
    logic [8:0][7:0]  cand;
    logic [8:0][15:0] distort, distort_s;
    logic             done, done_s, busy, busy_s;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int strobes = 0;
    int strobes_s = 0;
    exp_t q64[$];
    exp_t q512[$];

    fme_sad_accum #(.NPIX(64)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .cur(cur), .cand(cand),
        .distort(distort), .done(done), .busy(busy)
    );

    fme_sad_accum #(.NPIX(512)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid_s), .cur(cur), .cand(cand),
        .distort(distort_s), .done(done_s), .busy(busy_s)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops an expected entry on every done strobe and checks value and latency
    logic             prev_rst = 1'b1;
    logic             prev_done = 1'b0, prev_done_s = 1'b0;
    logic [8:0][15:0] last_d = '0, last_ds = '0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst && !prev_rst) begin
            if (done) begin
                strobes++;
                tests++;
                if (q64.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_done64: got done=1 at cycle %0d, required no strobe", cyc);
                end else begin
                    e = q64.pop_front();
                    if (distort !== e.v || cyc != e.cyc) begin
                        fails++;
                        $display("FAIL distort64: got %h at cycle %0d, required %h at cycle %0d",
                                 distort, cyc, e.v, e.cyc);
                    end else
                        $display("[TB] block64 done cycle %0d distort %h", cyc, distort);
                end
                if (prev_done) begin
                    tests++; fails++;
                    $display("FAIL strobe_sep64: got done on consecutive cycles, required separation");
                end
            end else if (distort !== last_d) begin
                tests++; fails++;
                $display("FAIL hold64: got %h without done, required %h", distort, last_d);
            end
            if (done_s) begin
                strobes_s++;
                tests++;
                if (q512.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_done512: got done=1 at cycle %0d, required no strobe", cyc);
                end else begin
                    e = q512.pop_front();
                    if (distort_s !== e.v || cyc != e.cyc) begin
                        fails++;
                        $display("FAIL distort512: got %h at cycle %0d, required %h at cycle %0d",
                                 distort_s, cyc, e.v, e.cyc);
                    end else
                        $display("[TB] block512 done cycle %0d distort %h", cyc, distort_s);
                end
            end else if (distort_s !== last_ds) begin
                tests++; fails++;
                $display("FAIL hold512: got %h without done, required %h", distort_s, last_ds);
            end
        end
        prev_rst    = rst;
        prev_done   = done;
        prev_done_s = done_s;
        last_d      = distort;
        last_ds     = distort_s;
    end

    task automatic idle();
        @(posedge clk); #1;
        in_valid   = 1'b0;
        in_valid_s = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        in_valid = 1'b0; in_valid_s = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic drive(input bit sel, input logic [7:0] c, input logic [8:0][7:0] cd);
        @(posedge clk); #1;
        cur        = c;
        cand       = cd;
        in_valid   = !sel;
        in_valid_s = sel;
    endtask

    task automatic send_block(input bit sel, input int n, input logic [7:0] c,
                              input logic [8:0][7:0] cd, input bit gaps,
                              input bit push, input logic [8:0][15:0] ev);
        exp_t e;
        for (int p = 0; p < n; p++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                int g = $urandom_range(1, 3);
                for (int k = 0; k < g; k++) idle();
            end
            drive(sel, c, cd);
            if (push && p == n - 1) begin
                e.v   = ev;
                e.cyc = cyc + 2;
                if (sel) q512.push_back(e); else q64.push_back(e);
            end
        end
    endtask

    task automatic check1(input string name, input logic got, input logic req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s: got %0b, required %0b", name, got, req);
        end else
            $display("[TB] %s ok (%0b)", name, got);
    endtask

    task automatic check_vec(input string name, input logic [8:0][15:0] got,
                             input logic [8:0][15:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end else
            $display("[TB] %s ok", name);
    endtask

    logic [8:0][7:0]  cd;
    logic [8:0][15:0] ev;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_valid_s = 1'b0; cur = '0; cand = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_vec("reset_distort", distort, '0);
        check1("reset_done", done, 1'b0);
        check1("reset_busy", busy, 1'b0);
        check1("reset_busy512", busy_s, 1'b0);

        // Uniform block: diff i on candidate i -> 64*i
        for (int i = 0; i < 9; i++) begin cd[i] = 8'(100 + i); ev[i] = 16'(64 * i); end
        send_block(0, 64, 8'd100, cd, 0, 1, ev);
        repeat (3) idle();
        @(negedge clk);
        check1("busy_after_block", busy, 1'b0);

        // Sign handling, both polarities back to back
        for (int i = 0; i < 9; i++) begin
            cd[i] = (i % 2 == 0) ? 8'd255 : 8'd0;
            ev[i] = (i % 2 == 0) ? 16'd16320 : 16'd0;
        end
        send_block(0, 64, 8'd0, cd, 0, 1, ev);
        for (int i = 0; i < 9; i++) ev[i] = (i % 2 == 0) ? 16'd0 : 16'd16320;
        send_block(0, 64, 8'd255, cd, 0, 1, ev);
        repeat (3) idle();

        // Back-to-back: block A diff 1, block B diff 2 with gaps
        for (int i = 0; i < 9; i++) begin cd[i] = 8'd11; ev[i] = 16'd64; end
        send_block(0, 64, 8'd10, cd, 0, 1, ev);
        for (int i = 0; i < 9; i++) begin cd[i] = 8'd8; ev[i] = 16'd128; end
        send_block(0, 64, 8'd10, cd, 1, 1, ev);
        repeat (3) idle();

        // Reset mid-block: the 30 partial pixels must vanish
        for (int i = 0; i < 9; i++) cd[i] = 8'd25;
        send_block(0, 30, 8'd20, cd, 0, 0, ev);
        idle();
        @(negedge clk);
        check1("busy_mid_block", busy, 1'b1);
        do_reset();
        @(negedge clk);
        check_vec("distort_after_rst", distort, '0);
        check1("busy_after_rst", busy, 1'b0);
        for (int i = 0; i < 9; i++) begin cd[i] = 8'd23; ev[i] = 16'd192; end
        send_block(0, 64, 8'd20, cd, 0, 1, ev);
        repeat (3) idle();

        // Comparator-style patterns: candidate 5 alone at diff 0, then 2 and 5 tied
        for (int i = 0; i < 9; i++) begin cd[i] = 8'd54; ev[i] = 16'd256; end
        cd[5] = 8'd50; ev[5] = 16'd0;
        send_block(0, 64, 8'd50, cd, 0, 1, ev);
        cd[2] = 8'd50; ev[2] = 16'd0; cd[3] = 8'd46;
        send_block(0, 64, 8'd50, cd, 0, 1, ev);
        repeat (3) idle();

        // Saturation on the 512-pixel instance, then a zero block
        for (int i = 0; i < 9; i++) begin cd[i] = 8'd255; ev[i] = 16'hFFFF; end
        send_block(1, 512, 8'd0, cd, 0, 1, ev);
        for (int i = 0; i < 9; i++) begin cd[i] = 8'd77; ev[i] = 16'd0; end
        send_block(1, 512, 8'd77, cd, 0, 1, ev);
        idle();

        for (int k = 0; k < 20 && (q64.size() != 0 || q512.size() != 0); k++) idle();
        tests++;
        if (q64.size() != 0 || q512.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d/%0d pending, required 0/0", q64.size(), q512.size());
        end
        tests++;
        if (strobes != 8 || strobes_s != 2) begin
            fails++;
            $display("FAIL strobe_count: got %0d/%0d, required 8/2", strobes, strobes_s);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fme_sad_accum.md
# fme_sad_accum

Distortion accumulator for the fractional motion estimation (FME) stage. It streams one current-block pixel and the nine co-located candidate pixels per cycle: the integer centre plus the eight half-pel neighbours. It accumulates nine sums of absolute differences (SAD) over a block of NPIX pixels. At block end it presents the nine 16-bit distortions and a one-cycle `done` strobe that drives the enable of the downstream best-candidate comparator.

## Interface
- `NPIX`, 64: pixels per block; any value 2..1024. Default is 8x8.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: `cur`/`cand` carry a valid pixel this cycle. Always accepted; there is no backpressure.
- `cur` input 8: current-block luma pixel, unsigned.
- `cand` input [8:0][7:0]: candidate pixels, unsigned.
  - Index 0..7 are the half-pel neighbours, in the order the comparator expects.
  - Index 8 is the integer centre.
- `distort` output [8:0][15:0]: per-candidate SAD of the last completed block.
- `done` output 1: one-cycle strobe; `distort` was updated this cycle. Wire it to the comparator `en`.
- `busy` output 1: a block is partially accumulated or in the pipeline.

## Operation
- **Stage 1 (diff), on each edge with `in_valid=1`:**
  - `diff[i] <= |cur - cand[i]|`, computed as an unsigned 8-bit magnitude (9-bit signed subtract, then absolute value).
  - `v1 <= 1`.
  - `last1 <= (pcnt == NPIX-1)`.
  - `pcnt` increments and wraps to 0 after NPIX-1.
- **Stage 1, on edges with `in_valid=0`:** `v1 <= 0`; `pcnt` holds.
- **Stage 2 (accumulate), when `v1=1`:**
  - `sum[i] = acc[i] + diff[i]`, computed at 17 bits and saturated to 16'hFFFF.
  - If `last1=0`: `acc[i] <= sum[i]`.
  - If `last1=1`: `distort[i] <= sum[i]`, `acc[i] <= 0`, `done <= 1`.
- **Stage 2, otherwise:** `done <= 0`; `acc` holds.
- **Back-to-back blocks:** pixel 0 of block n+1 may directly follow the last pixel of block n.
  - It must accumulate into a zero accumulator.
  - No bubble is required.
  - `acc` is zeroed on the same edge that writes `distort`.
- **Gaps:** `in_valid` may drop anywhere, for any number of cycles, mid-block. Counting and accumulation simply pause.
- **Holding:** `distort` holds its value between `done` strobes.
- **`busy`:** `busy = (pcnt != 0) | v1`.
- **Saturation:** at NPIX ≤ 257 the sum never exceeds 65535, so saturation cannot trigger. It is still required, so larger NPIX values stay well-defined. A saturated sum stays saturated for the rest of its block.
- **Reset (`rst=1` at an edge):**
  - `pcnt=0`, `v1=0`, `last1=0`, all `acc=0`, all `distort=0`, `done=0`.
  - `rst` has priority over `in_valid`.
  - A block interrupted by reset is discarded and produces no `done`.
  - The first valid pixel after reset is pixel 0.

## Timing
- **Latency:** last pixel of a block presented in cycle t (`in_valid` high, sampled at the end of t) → `done=1` and new `distort` visible in cycle t+2.
- The comparator's registered `best` is then valid in cycle t+3.
- **Throughput:** one pixel per cycle sustained; one block every NPIX cycles.
- **Strobe separation:** `done` is never high on consecutive cycles, because NPIX ≥ 2.
- **Reset values:** `distort=0`, `done=0`, `busy=0`.
- **Path depth:** the subtract/abs path and the add/saturate path are each confined to one register stage. There is no combinational path from any input to any output.

## Test plan
- **Uniform block:** NPIX=64, reset, then 64 contiguous pixels with `cur=100`, `cand[i]=100+i` → in cycle t+2 `distort[i]=64*i` (0, 64, …, 512), `done` high exactly one cycle, `busy` low afterwards.
- **Sign handling:** `cur=0`, `cand[i]=255` for `i` even and `cand[i]=0` for `i` odd, 64 pixels → even entries 16320, odd entries 0. Then swap to `cur=255` with the same candidates → even entries 0, odd entries 16320.
- **Back-to-back with gaps:** block A (all diffs 1) followed immediately by block B (all diffs 2), with random `in_valid` gaps inside B → first `done` gives `distort=64`, second gives 128, and exactly two strobes occur.
- **Reset mid-block:** assert `rst` after 30 pixels, then send a full block with all diffs 3 → no `done` for the partial block, one `done` with `distort=192`.
- **Saturation (NPIX=512):** `cur=0`, `cand=255` → `distort=16'hFFFF` for all i, and the next block with diff 0 gives 0.
- **Integration with the comparator:** `cand[5]` closest to `cur` (diff 0, all others diff 4) → `best=5` one cycle after `done`. With the diffs of `cand[2]` and `cand[5]` both 0 → `best=2` (the lower index wins ties).
